sp_memory_arbiter: RTL and testbench

- Round-robin arbiter that shares one sp_memory instance among NUM_REQ requesters.
- Each requester presents a single-word read or write and holds it until acknowledged.
- The arbiter drives the sp_memory cs/we/addr/wdata/wstrb pins directly and returns read data with a one-cycle ack.
- It sits between on-chip masters (DMA, CPU-side ports) and a single-port RAM macro, so one memory can replace several.

---
 rtl/sp_memory_arbiter.sv | 77 +++++++
 tb/tb_sp_memory_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_memory_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters.
// Issue is combinational, ack is a registered one-cycle pulse with the read data.
module sp_memory_arbiter #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int NUM_REQ = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int IW = $clog2(NUM_REQ),
   localparam int SW = WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_we,
   input  logic [NUM_REQ*AW-1:0]   req_addr,
   input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*SW-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [WIDTH-1:0]        rsp_rdata,
   output logic                    mem_cs,
   output logic                    mem_we,
   output logic [AW-1:0]           mem_addr,
   output logic [WIDTH-1:0]        mem_wdata,
   output logic [SW-1:0]           mem_wstrb,
   input  logic [WIDTH-1:0]        mem_rdata,
   output logic [IW-1:0]           grant_idx
);

   logic [NUM_REQ-1:0] pending;
   logic [NUM_REQ-1:0] eligible;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      win;
   logic               found;
   logic               issue;

   // A requester in its ack cycle is masked so it cannot be issued twice.
   assign eligible = req_valid & ~pending;

   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   // Gated by rst_n so the RAM never sees a select while reset is asserted.
   assign issue     = found & rst_n;
   assign mem_cs    = issue;
   assign mem_we    = issue & req_we[win];
   assign mem_addr  = issue ? req_addr[win*AW +: AW]        : '0;
   assign mem_wdata = issue ? req_wdata[win*WIDTH +: WIDTH] : '0;
   assign mem_wstrb = issue ? req_wstrb[win*SW +: SW]       : '0;
   assign grant_idx = issue ? win : '0;

   assign req_ack   = pending;
   assign rsp_rdata = (|pending) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         rr_ptr  <= '0;
      end else if (found) begin
         pending <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
         rr_ptr  <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end else begin
         pending <= '0;
      end
   end

endmodule

// File: tb/tb_sp_memory_arbiter.sv
// Directed bench for sp_memory_arbiter with a behavioural single-port RAM
// (registered read, byte-strobed write) attached to the memory pins.
module tb_sp_memory_arbiter;

   localparam int WIDTH = 32;
   localparam int DEPTH = 1024;
   localparam int NR    = 4;
   localparam int AW    = 10;
   localparam int IW    = 2;
   localparam int SW    = 4;

   logic                  clk;
   logic                  rst_n;
   logic [NR-1:0]         req_valid;
   logic [NR-1:0]         req_we;
   logic [NR*AW-1:0]      req_addr;
   logic [NR*WIDTH-1:0]   req_wdata;
   logic [NR*SW-1:0]      req_wstrb;
   logic [NR-1:0]         req_ack;
   logic [WIDTH-1:0]      rsp_rdata;
   logic                  mem_cs;
   logic                  mem_we;
   logic [AW-1:0]         mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [SW-1:0]         mem_wstrb;
   logic [WIDTH-1:0]      mem_rdata;
   logic [IW-1:0]         grant_idx;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] ram [0:DEPTH-1];
   logic [WIDTH-1:0] vals [0:3];
   logic [WIDTH-1:0] rd;

   sp_memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_ack(req_ack), .rsp_rdata(rsp_rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .grant_idx(grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we) begin
            for (int b = 0; b < SW; b++)
               if (mem_wstrb[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
      req_valid[i]               = v;
      req_we[i]                  = we;
      req_addr[i*AW +: AW]       = a;
      req_wdata[i*WIDTH +: WIDTH] = d;
      req_wstrb[i*SW +: SW]      = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lone requester i: issue this cycle, ack next cycle, drop valid in the ack cycle.
   task automatic do_access(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                            output logic [WIDTH-1:0] rdata);
      set_req(i, 1'b1, we, a, d, s);
      #1;
      chk("acc_cs", 64'(mem_cs), 64'd1);
      chk("acc_grant", 64'(grant_idx), 64'(i));
      chk("acc_we", 64'(mem_we), 64'(we));
      chk("acc_addr", 64'(mem_addr), 64'(a));
      if (we) chk("acc_wstrb", 64'(mem_wstrb), 64'(s));
      step();
      chk("acc_ack", 64'(req_ack), 64'(4'b0001 << i));
      rdata = rsp_rdata;
      set_req(i, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("acc_idle_cs", 64'(mem_cs), 64'd0);
      step();
      chk("acc_ack_clr", 64'(req_ack), 64'd0);
   endtask

   initial begin
      vals[0] = 32'hA5A5_0000;
      vals[1] = 32'h1234_5671;
      vals[2] = 32'h0BAD_F00D;
      vals[3] = 32'hCAFE_0003;

      // Reset gating: requests present and writing, yet no RAM activity.
      rst_n     = 1'b0;
      req_valid = '1;
      req_we    = '1;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '1;
      #1;
      chk("rst_cs", 64'(mem_cs), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_ack", 64'(req_ack), 64'd0);
      chk("rst_grant", 64'(grant_idx), 64'd0);
      step();
      step();
      req_valid = '0;
      req_we    = '0;
      req_wstrb = '0;
      rst_n     = 1'b1;
      #1;
      chk("idle_cs", 64'(mem_cs), 64'd0);

      // Write then read back, requester 0.
      do_access(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, rd);
      do_access(0, 1'b0, 10'h010, 32'h0, 4'h0, rd);
      chk("rd_deadbeef", 64'(rd), 64'hDEADBEEF);

      // Byte strobes, including an all-zero strobe write.
      do_access(1, 1'b1, 10'h005, 32'hFFFFFFFF, 4'hF, rd);
      do_access(1, 1'b1, 10'h005, 32'h00000000, 4'b0101, rd);
      do_access(1, 1'b0, 10'h005, 32'h0, 4'h0, rd);
      chk("rd_strb", 64'(rd), 64'hFF00FF00);
      do_access(1, 1'b1, 10'h005, 32'h12345678, 4'h0, rd);
      do_access(1, 1'b0, 10'h005, 32'h0, 4'h0, rd);
      chk("rd_strb0", 64'(rd), 64'hFF00FF00);

      for (int k = 0; k < 4; k++) do_access(k, 1'b1, AW'(32 + k), vals[k], 4'hF, rd);

      // Reset pulse to bring rr_ptr back to 0, then all four read at once.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, AW'(32 + k), '0, '0);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_cs", 64'(mem_cs), 64'd1);
         chk("rr_grant", 64'(grant_idx), 64'(k));
         step();
         chk("rr_ack", 64'(req_ack), 64'(4'b0001 << k));
         chk("rr_rdata", 64'(rsp_rdata), 64'(vals[k]));
         set_req(k, 1'b0, 1'b0, '0, '0, '0);
         #1;
      end
      chk("rr_done_cs", 64'(mem_cs), 64'd0);
      step();

      // Requester 2 streaming alone: one access every two cycles.
      set_req(2, 1'b1, 1'b0, AW'(32), '0, '0);
      for (int n = 0; n < 4; n++) begin
         #1;
         chk("st_cs", 64'(mem_cs), 64'd1);
         chk("st_grant", 64'(grant_idx), 64'd2);
         step();
         chk("st_ack", 64'(req_ack), 64'b0100);
         chk("st_rdata", 64'(rsp_rdata), 64'(vals[n]));
         chk("st_no_reissue", 64'(mem_cs), 64'd0);
         if (n < 3) set_req(2, 1'b1, 1'b0, AW'(33 + n), '0, '0);
         else       set_req(2, 1'b0, 1'b0, '0, '0, '0);
         step();
         chk("st_ack_clr", 64'(req_ack), 64'd0);
      end

      // Wrap and skip: rr_ptr is 3 after requester 2.
      set_req(3, 1'b1, 1'b0, AW'(35), '0, '0);
      set_req(0, 1'b1, 1'b0, AW'(32), '0, '0);
      #1;
      chk("wr_grant3", 64'(grant_idx), 64'd3);
      step();
      chk("wr_ack3", 64'(req_ack), 64'b1000);
      set_req(3, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("wr_grant0", 64'(grant_idx), 64'd0);
      chk("wr_cs0", 64'(mem_cs), 64'd1);
      step();
      chk("wr_ack0", 64'(req_ack), 64'b0001);
      chk("wr_rdata0", 64'(rsp_rdata), 64'(vals[0]));
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1, 1'b1, 1'b0, AW'(33), '0, '0);
      #1;
      chk("wr_grant1", 64'(grant_idx), 64'd1);
      step();
      chk("wr_ack1", 64'(req_ack), 64'b0010);
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      step();

      // Reset in the ack cycle of a read; rr_ptr was 2 so grant 1 over 3 proves it cleared.
      set_req(1, 1'b1, 1'b0, AW'(34), '0, '0);
      step();
      chk("mr_ack", 64'(req_ack), 64'b0010);
      rst_n = 1'b0;
      set_req(3, 1'b1, 1'b0, AW'(35), '0, '0);
      #1;
      chk("mr_ack_lost", 64'(req_ack), 64'd0);
      chk("mr_cs", 64'(mem_cs), 64'd0);
      chk("mr_rsp", 64'(rsp_rdata), 64'd0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mr_reissue_cs", 64'(mem_cs), 64'd1);
      chk("mr_reissue_grant", 64'(grant_idx), 64'd1);
      step();
      chk("mr_ack1", 64'(req_ack), 64'b0010);
      chk("mr_rdata1", 64'(rsp_rdata), 64'(vals[2]));
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      #1;
      chk("mr_grant3", 64'(grant_idx), 64'd3);
      step();
      chk("mr_ack3", 64'(req_ack), 64'b1000);
      chk("mr_rdata3", 64'(rsp_rdata), 64'(vals[3]));
      set_req(3, 1'b0, 1'b0, '0, '0, '0);
      step();
      chk("end_ack", 64'(req_ack), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
